// File: rtl/spi_pkg.sv
// Shared SPI follower types: FSM states, frame sizes and error bit positions.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, ABORT} state_t;

  localparam int         FRAME_W   = 16;
  localparam logic [4:0] LEN8      = 5'd8;
  localparam logic [4:0] LEN16     = 5'd16;
  localparam int         ERR_UNDER = 0;
  localparam int         ERR_OVER  = 1;
  localparam int         ERR_FRAME = 2;

  function automatic logic [4:0] frame_len(input logic len16);
    return len16 ? LEN16 : LEN8;
  endfunction
endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer plus one-flop edge detect; level is valid SYNC_STAGES clk
// after the pin, rise/fall pulse for one clk in that same cycle. No backpressure.
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_dout,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_dout = r_sync[SYNC_STAGES-1];
  assign o_rise = o_dout & ~r_prev;
  assign o_fall = ~o_dout & r_prev;
endmodule

// File: rtl/spi_follower.sv
// SPI follower: over-sampled pins, SYNC_STAGES+1 clk pin-to-action, TX valid/ready and RX valid/ack.
// Define SPI_FOLLOWER_ECHO_EN to resend the previous rx_data when no TX word is queued.
module spi_follower
  import spi_pkg::*;
#(
  parameter int                 SYNC_STAGES = 2,
  parameter logic [FRAME_W-1:0] FILL_WORD   = 16'hFFFF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cpol,
  input  logic               i_cpha,
  input  logic               i_len16,
  input  logic               i_sclk,
  input  logic               i_cs_n,
  input  logic               i_mosi,
  output logic               o_miso,
  output logic               o_miso_oe,
  input  logic [FRAME_W-1:0] i_tx_data,
  input  logic               i_tx_valid,
  output logic               o_tx_ready,
  output logic [FRAME_W-1:0] o_rx_data,
  output logic               o_rx_valid,
  input  logic               i_rx_ack,
  output logic               o_busy,
  output logic [2:0]         o_err,
  input  logic               i_clr_err
);
  state_t r_state, w_state_nxt;

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  logic               r_cpol, r_cpha, r_len16;
  logic [4:0]         r_cnt;
  logic [FRAME_W-1:0] r_tx_shift, r_rx_shift, r_tx_shadow, r_rx_data;
  logic               r_tx_full, r_rx_valid;
  logic [2:0]         r_err;

  logic               w_mosi, w_edge, w_lead, w_trail, w_active, w_start;
  logic               w_sample, w_shift, w_under, w_over, w_frame_err;
  logic [4:0]         w_len;
  logic [FRAME_W-1:0] w_fill;
  logic               w_under_en;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_din(i_sclk),
    .o_dout(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  // cs_n resets to "selected" so a pin held low through reset never looks like a fresh fall.
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_din(i_cs_n),
    .o_dout(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_mosi_sync <= '0;
    else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // Leading edge moves sclk away from its idle (cpol) level.
  assign w_edge   = w_sclk_rise | w_sclk_fall;
  assign w_lead   = w_edge & (w_sclk_lvl != r_cpol);
  assign w_trail  = w_edge & (w_sclk_lvl == r_cpol);
  assign w_len    = frame_len(r_len16);
  assign w_active = (r_state == ACTIVE);
  assign w_start  = (r_state == IDLE) & w_cs_fall;
  assign w_sample = w_active & (r_cnt != w_len) & (r_cpha ? w_trail : w_lead);
  assign w_shift  = w_active & (r_cpha ? (w_lead & (r_cnt != 5'd0)) : w_trail);

`ifdef SPI_FOLLOWER_ECHO_EN
  assign w_fill     = r_rx_data;
  assign w_under_en = 1'b0;
`else
  assign w_fill     = FILL_WORD;
  assign w_under_en = 1'b1;
`endif

  assign w_under     = w_start & ~r_tx_full & w_under_en;
  assign w_over      = (r_state == DONE) & r_rx_valid & ~i_rx_ack;
  assign w_frame_err = w_active & (r_cnt != w_len) & w_cs_rise;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = ACTIVE;
      ACTIVE: begin
        if (r_cnt == w_len)  w_state_nxt = DONE;
        else if (w_cs_rise)  w_state_nxt = IDLE;
      end
      DONE:    w_state_nxt = ABORT;
      ABORT:   if (w_cs_lvl) w_state_nxt = IDLE;
      default: w_state_nxt = ABORT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ABORT;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cpol <= 1'b0; r_cpha <= 1'b0; r_len16 <= 1'b0;
      r_cnt <= '0; r_tx_shift <= '0; r_rx_shift <= '0;
      r_tx_shadow <= '0; r_tx_full <= 1'b0;
      r_rx_data <= '0; r_rx_valid <= 1'b0; r_err <= '0;
    end else begin
      if (w_start) begin
        {r_cpol, r_cpha, r_len16} <= {i_cpol, i_cpha, i_len16};
        r_cnt      <= '0;
        r_rx_shift <= '0;
        r_tx_shift <= r_tx_full ? r_tx_shadow : w_fill;
      end else begin
        if (w_sample) begin
          r_rx_shift <= {r_rx_shift[FRAME_W-2:0], w_mosi};
          r_cnt      <= r_cnt + 5'd1;
        end
        if (w_shift) r_tx_shift <= {r_tx_shift[FRAME_W-2:0], 1'b0};
      end

      // Start empties the shadow; a word offered in that same cycle is kept for the next frame.
      if (i_tx_valid & ~r_tx_full) begin
        r_tx_shadow <= i_tx_data;
        r_tx_full   <= 1'b1;
      end else if (w_start) begin
        r_tx_full <= 1'b0;
      end

      if (r_state == DONE) begin
        r_rx_data  <= r_len16 ? r_rx_shift : {8'h00, r_rx_shift[7:0]};
        r_rx_valid <= 1'b1;
      end else if (i_rx_ack) begin
        r_rx_valid <= 1'b0;
      end

      r_err <= (i_clr_err ? 3'b000 : r_err) | {w_frame_err, w_over, w_under};
    end
  end

  assign o_miso     = w_active & (r_len16 ? r_tx_shift[15] : r_tx_shift[7]);
  assign o_miso_oe  = w_active;
  assign o_tx_ready = ~r_tx_full;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = w_active | (r_state == DONE);
  assign o_err      = r_err;
endmodule

// File: tb/tb_spi_follower.sv
// Leader-side bench for spi_follower: drives SPI frames on the pins and scoreboards rx/miso words.
`timescale 1ns/1ps
module tb_spi_follower;
  localparam int H = 8;  // sclk half period in clk cycles

  logic        clk = 1'b0, rst = 1'b1;
  logic        cpol = 1'b0, cpha = 1'b0, len16 = 1'b0;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0, rx_ack = 1'b0, clr_err = 1'b0;
  logic        miso, miso_oe, tx_ready, rx_valid, busy;
  logic [15:0] rx_data;
  logic [2:0]  err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] rx_q[$];
  logic [15:0] miso_q[$];

  spi_follower dut (
    .i_clk(clk), .i_rst(rst), .i_cpol(cpol), .i_cpha(cpha), .i_len16(len16),
    .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi), .o_miso(miso), .o_miso_oe(miso_oe),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ack(rx_ack),
    .o_busy(busy), .o_err(err), .i_clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic queue_tx(input logic [15:0] w);
    @(negedge clk); tx_data = w; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
  endtask

  task automatic ack_rx();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  // Leader engine: sends nbits of mosi_w (MSB first) and captures miso on the leader's sample edges.
  task automatic spi_xfer(input logic pol, input logic pha, input logic l16,
                          input logic [15:0] mosi_w, input int nbits, input bit ack_on_done,
                          output logic [15:0] miso_w, output bit oe_ok);
    int n;
    logic b;
    n = l16 ? 16 : 8;
    miso_w = '0;
    oe_ok = 1'b1;
    @(negedge clk); cpol = pol; cpha = pha; len16 = l16; sclk = pol;
    repeat (6) @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = mosi_w[n-1-i];
      if (!pha) mosi = b;
      repeat (H) @(negedge clk);
      sclk = ~sclk;
      if (pha) mosi = b;
      else begin
        miso_w = {miso_w[14:0], miso};
        oe_ok = oe_ok & miso_oe & busy;
      end
      if (!pha && ack_on_done && i == n-1) begin
        repeat (4) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        repeat (H-5) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      sclk = ~sclk;
      if (pha) begin
        miso_w = {miso_w[14:0], miso};
        oe_ok = oe_ok & miso_oe & busy;
      end
    end
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({miso, miso_oe, tx_ready, rx_valid, busy, err} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want %b", {miso, miso_oe, tx_ready, rx_valid, busy, err}, 8'b00100000);
    end
    n_checks++;
    if (rx_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rx_data: got %h want 0000", rx_data); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [15:0] cap, exp;
    bit oe;
    queue_tx(16'h00A5);
    n_checks++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL mode0_tx_ready_full: got %b want 0", tx_ready); end
    miso_q.push_back(16'h00A5);
    rx_q.push_back(16'h003C);
    spi_xfer(1'b0, 1'b0, 1'b0, 16'h003C, 8, 1'b0, cap, oe);
    exp = miso_q.pop_front();
    n_checks++;
    if (cap[7:0] !== exp[7:0]) begin n_fail++; $display("FAIL mode0_miso: got %h want %h", cap[7:0], exp[7:0]); end
    n_checks++;
    if (oe !== 1'b1) begin n_fail++; $display("FAIL mode0_oe_busy: got %b want 1", oe); end
    exp = rx_q.pop_front();
    n_checks++;
    if (rx_data !== exp) begin n_fail++; $display("FAIL mode0_rx_data: got %h want %h", rx_data, exp); end
    n_checks++;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL mode0_rx_valid: got %b want 1", rx_valid); end
    n_checks++;
    if (err !== 3'b000) begin n_fail++; $display("FAIL mode0_err: got %b want 000", err); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL mode0_tx_ready_empty: got %b want 1", tx_ready); end
    ack_rx();
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mode0_rx_ack: got %b want 0", rx_valid); end
  endtask

  task automatic test_modes();
    logic [15:0] cap, exp;
    bit oe;
    for (int m = 1; m < 4; m++) begin
      queue_tx(16'hBEEF);
      miso_q.push_back(16'hBEEF);
      rx_q.push_back(16'h1234);
      spi_xfer(m[1], m[0], 1'b1, 16'h1234, 16, 1'b0, cap, oe);
      exp = miso_q.pop_front();
      n_checks++;
      if (cap !== exp) begin n_fail++; $display("FAIL mode%0d_miso: got %h want %h", m, cap, exp); end
      exp = rx_q.pop_front();
      n_checks++;
      if (rx_data !== exp) begin n_fail++; $display("FAIL mode%0d_rx_data: got %h want %h", m, rx_data, exp); end
      n_checks++;
      if (err !== 3'b000) begin n_fail++; $display("FAIL mode%0d_err: got %b want 000", m, err); end
      ack_rx();
    end
  endtask

  task automatic test_underrun();
    logic [15:0] cap, exp;
    logic [2:0]  exp_err;
    bit oe;
`ifdef SPI_FOLLOWER_ECHO_EN
    miso_q.push_back(16'h1234);
    exp_err = 3'b000;
`else
    miso_q.push_back(16'hFFFF);
    exp_err = 3'b001;
`endif
    rx_q.push_back(16'h5A5A);
    spi_xfer(1'b0, 1'b0, 1'b1, 16'h5A5A, 16, 1'b0, cap, oe);
    exp = miso_q.pop_front();
    n_checks++;
    if (cap !== exp) begin n_fail++; $display("FAIL underrun_miso: got %h want %h", cap, exp); end
    n_checks++;
    if (err !== exp_err) begin n_fail++; $display("FAIL underrun_err: got %b want %b", err, exp_err); end
    exp = rx_q.pop_front();
    n_checks++;
    if (rx_data !== exp) begin n_fail++; $display("FAIL underrun_rx_data: got %h want %h", rx_data, exp); end
    clear_err();
    n_checks++;
    if (err !== 3'b000) begin n_fail++; $display("FAIL underrun_clr_err: got %b want 000", err); end
    ack_rx();
  endtask

  task automatic test_overrun();
    logic [15:0] cap, exp;
    bit oe;
    queue_tx(16'h00C3);
    spi_xfer(1'b0, 1'b0, 1'b0, 16'h0011, 8, 1'b0, cap, oe);
    queue_tx(16'h003C);
    rx_q.push_back(16'h0022);
    spi_xfer(1'b0, 1'b0, 1'b0, 16'h0022, 8, 1'b0, cap, oe);
    exp = rx_q.pop_front();
    n_checks++;
    if (rx_data !== exp) begin n_fail++; $display("FAIL overrun_rx_data: got %h want %h", rx_data, exp); end
    n_checks++;
    if (err !== 3'b010) begin n_fail++; $display("FAIL overrun_err: got %b want 010", err); end
    clear_err();
    queue_tx(16'h0081);
    rx_q.push_back(16'h0033);
    spi_xfer(1'b0, 1'b0, 1'b0, 16'h0033, 8, 1'b1, cap, oe);
    exp = rx_q.pop_front();
    n_checks++;
    if (rx_data !== exp) begin n_fail++; $display("FAIL ack_done_rx_data: got %h want %h", rx_data, exp); end
    n_checks++;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ack_done_rx_valid: got %b want 1", rx_valid); end
    n_checks++;
    if (err !== 3'b000) begin n_fail++; $display("FAIL ack_done_err: got %b want 000", err); end
    ack_rx();
  endtask

  task automatic test_frame_err();
    logic [15:0] cap, exp;
    bit oe;
    queue_tx(16'h0042);
    spi_xfer(1'b0, 1'b0, 1'b0, 16'h00FF, 5, 1'b0, cap, oe);
    n_checks++;
    if (err !== 3'b100) begin n_fail++; $display("FAIL frame_err_err: got %b want 100", err); end
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL frame_err_rx_valid: got %b want 0", rx_valid); end
    clear_err();
    queue_tx(16'h0069);
    miso_q.push_back(16'h0069);
    rx_q.push_back(16'h0096);
    spi_xfer(1'b0, 1'b0, 1'b0, 16'h0096, 8, 1'b0, cap, oe);
    exp = miso_q.pop_front();
    n_checks++;
    if (cap[7:0] !== exp[7:0]) begin n_fail++; $display("FAIL frame_err_next_miso: got %h want %h", cap[7:0], exp[7:0]); end
    exp = rx_q.pop_front();
    n_checks++;
    if (rx_data !== exp) begin n_fail++; $display("FAIL frame_err_next_rx: got %h want %h", rx_data, exp); end
    n_checks++;
    if ({rx_valid, err} !== 4'b1000) begin n_fail++; $display("FAIL frame_err_next_status: got %b want 1000", {rx_valid, err}); end
    ack_rx();
  endtask

  task automatic test_reset_midframe();
    logic [15:0] cap, exp;
    bit oe;
    queue_tx(16'h00AA);
    fork
      spi_xfer(1'b0, 1'b0, 1'b0, 16'h0055, 8, 1'b0, cap, oe);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({miso, miso_oe, tx_ready, rx_valid, busy, err} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000}) begin
          n_fail++;
          $display("FAIL midrst_ctrl: got %b want %b", {miso, miso_oe, tx_ready, rx_valid, busy, err}, 8'b00100000);
        end
        n_checks++;
        if (rx_data !== 16'h0000) begin n_fail++; $display("FAIL midrst_rx_data: got %h want 0000", rx_data); end
      end
    join
    n_checks++;
    if ({rx_valid, busy, err} !== 5'b00000) begin
      n_fail++; $display("FAIL midrst_after_frame: got %b want 00000", {rx_valid, busy, err});
    end
    queue_tx(16'h00E7);
    miso_q.push_back(16'h00E7);
    rx_q.push_back(16'h0018);
    spi_xfer(1'b0, 1'b0, 1'b0, 16'h0018, 8, 1'b0, cap, oe);
    exp = miso_q.pop_front();
    n_checks++;
    if (cap[7:0] !== exp[7:0]) begin n_fail++; $display("FAIL midrst_next_miso: got %h want %h", cap[7:0], exp[7:0]); end
    exp = rx_q.pop_front();
    n_checks++;
    if (rx_data !== exp) begin n_fail++; $display("FAIL midrst_next_rx: got %h want %h", rx_data, exp); end
    n_checks++;
    if ({rx_valid, err} !== 4'b1000) begin n_fail++; $display("FAIL midrst_next_status: got %b want 1000", {rx_valid, err}); end
    ack_rx();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_underrun();
    test_overrun();
    test_frame_err();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
